// File: rtl/x25519_pkg.sv
`default_nettype none
// ============================================================================
// Module   : x25519_pkg
// Brief    : Shared constants and state encoding for the X25519 datapath.
// Revision : 1.0
// ============================================================================
package x25519_pkg;

    localparam int X25519_LIMB_BITS = 8;
    localparam int X25519_NUM_LIMBS = 32;

    // p = 2^255 - 19: limb0 = 0xED, limbs 1..30 = 0xFF, limb31 = 0x7F
    localparam logic [255:0] P_25519 = {1'b0, {250{1'b1}}, 5'b01101};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_STREAM = 2'd2
    } x25519_emit_state_t;

endpackage
`default_nettype wire

// File: rtl/x25519_freeze.sv
`default_nettype none
// ============================================================================
// Module   : x25519_freeze
// Brief    : Combinational single conditional subtraction of p (v < 2p assumed).
// Revision : 1.0
// ============================================================================
module x25519_freeze
    import x25519_pkg::*;
(
    input  logic [255:0] v,
    output logic [255:0] r,
    output logic         borrow
);

    logic [256:0] diff;

    assign diff   = {1'b0, v} - {1'b0, P_25519};
    assign borrow = diff[256];
    // A borrow means v < p, so v is already canonical.
    assign r      = borrow ? v : diff[255:0];

endmodule
`default_nettype wire

// File: rtl/x25519_streaming_emit.sv
`default_nettype none
// ============================================================================
// Module   : x25519_streaming_emit
// Brief    : Optionally freezes a field element mod p, then streams its 32
//            byte limbs as indexed 32-bit words with ready/valid handshake.
// Revision : 1.0
// ============================================================================
module x25519_streaming_emit
    import x25519_pkg::*;
#(
    parameter int FREEZE    = 1,
    parameter int NUM_LIMBS = X25519_NUM_LIMBS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [263:0] a,
    output logic         busy,
    output logic         dout_valid,
    output logic [4:0]   dout_count,
    output logic [31:0]  dout,
    input  logic         dout_ready,
    output logic         done
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_LIMBS - 1);

    x25519_emit_state_t state_q, state_d;
    logic [255:0]       operand_q, operand_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               dout_valid_q, dout_valid_d;
    logic [4:0]         dout_count_q, dout_count_d;
    logic [31:0]        dout_q, dout_d;
    logic               done_q, done_d;

    logic [255:0]       frz_r;
    logic               frz_borrow;
    logic [4:0]         cnt_inc;
    logic [7:0]         next_limb;
    logic               unused_bits;

    x25519_freeze u_freeze (
        .v      (operand_q),
        .r      (frz_r),
        .borrow (frz_borrow)
    );

    // Top byte of a is architecturally zero; the borrow is folded into r.
    assign unused_bits = ^{a[263:256], frz_borrow};

    assign cnt_inc   = cnt_q + 5'd1;
    assign next_limb = operand_q[{cnt_inc, 3'b000} +: 8];

    always_comb begin
        state_d      = state_q;
        operand_d    = operand_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        dout_valid_d = dout_valid_q;
        dout_count_d = dout_count_q;
        dout_d       = dout_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The done cycle is still part of the previous operation.
                if (en && !done_q) begin
                    operand_d = a[255:0];
                    cnt_d     = 5'd0;
                    busy_d    = 1'b1;
                    if (FREEZE != 0) begin
                        state_d = ST_REDUCE;
                    end else begin
                        state_d      = ST_STREAM;
                        dout_valid_d = 1'b1;
                        dout_count_d = 5'd0;
                        dout_d       = {24'h0, a[7:0]};
                    end
                end
            end
            ST_REDUCE: begin
                operand_d    = frz_r;
                state_d      = ST_STREAM;
                dout_valid_d = 1'b1;
                dout_count_d = 5'd0;
                dout_d       = {24'h0, frz_r[7:0]};
            end
            ST_STREAM: begin
                if (dout_valid_q && dout_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d      = ST_IDLE;
                        cnt_d        = 5'd0;
                        busy_d       = 1'b0;
                        dout_valid_d = 1'b0;
                        dout_count_d = 5'd0;
                        dout_d       = 32'h0;
                        done_d       = 1'b1;
                    end else begin
                        cnt_d        = cnt_inc;
                        dout_count_d = cnt_inc;
                        dout_d       = {24'h0, next_limb};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            operand_q    <= 256'h0;
            cnt_q        <= 5'd0;
            busy_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_count_q <= 5'd0;
            dout_q       <= 32'h0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            operand_q    <= operand_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            dout_valid_q <= dout_valid_d;
            dout_count_q <= dout_count_d;
            dout_q       <= dout_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign dout_valid = dout_valid_q;
    assign dout_count = dout_count_q;
    assign dout       = dout_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_x25519_streaming_emit.sv
`default_nettype none
// ============================================================================
// Module   : tb_x25519_streaming_emit
// Brief    : Directed self-checking bench for both FREEZE settings.
// Revision : 1.0
// ============================================================================
module tb_x25519_streaming_emit;

    localparam logic [255:0] C_P      = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [255:0] C_P_M1   = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffec;
    localparam logic [255:0] C_P_P5   = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffff2;
    localparam logic [255:0] C_RAMP   = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [255:0] C_ONE    = 256'h1;
    localparam logic [255:0] C_FIVE   = 256'h5;
    localparam logic [255:0] C_ZERO   = 256'h0;
    localparam logic [255:0] C_AB     = 256'hab;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         sel;
    logic [263:0] a;
    logic         dout_ready;

    logic         en1, busy1, dv1, done1;
    logic [4:0]   dc1;
    logic [31:0]  dd1;
    logic         en0, busy0, dv0, done0;
    logic [4:0]   dc0;
    logic [31:0]  dd0;

    logic         busy, dv, done;
    logic [4:0]   dc;
    logic [31:0]  dd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign en1  = en & sel;
    assign en0  = en & ~sel;
    assign busy = sel ? busy1 : busy0;
    assign dv   = sel ? dv1   : dv0;
    assign done = sel ? done1 : done0;
    assign dc   = sel ? dc1   : dc0;
    assign dd   = sel ? dd1   : dd0;

    x25519_streaming_emit #(.FREEZE(1), .NUM_LIMBS(32)) u_dut_frz (
        .clk(clk), .rst_n(rst_n), .en(en1), .a(a), .busy(busy1),
        .dout_valid(dv1), .dout_count(dc1), .dout(dd1),
        .dout_ready(dout_ready), .done(done1)
    );

    x25519_streaming_emit #(.FREEZE(0), .NUM_LIMBS(32)) u_dut_raw (
        .clk(clk), .rst_n(rst_n), .en(en0), .a(a), .busy(busy0),
        .dout_valid(dv0), .dout_count(dc0), .dout(dd0),
        .dout_ready(dout_ready), .done(done0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high; mode 1: ready toggles, held low 5 cycles at idx 17.
    task automatic run_op(input bit frz, input logic [255:0] val, input logic [255:0] expv,
                          input int mode, input bit inject, input int abort_idx);
        int cyc, exp_idx, first_v, done_cyc, stall_left;
        bit stalled;
        logic [31:0] hold_d;
        logic [4:0]  hold_c;
        cyc = 0; exp_idx = 0; first_v = -1; done_cyc = -1; stall_left = 5;
        stalled = 1'b0; hold_d = '0; hold_c = '0;
        sel = frz;
        a   = {8'h0, val};
        en  = 1'b1;
        dout_ready = 1'b1;
        tick();
        cyc = 1;
        check("busy_cycle1", busy, 1);
        while (done_cyc < 0 && cyc < 300) begin
            en = 1'b0;
            if (mode == 1 && exp_idx == 17 && stall_left > 0) begin
                dout_ready = 1'b0;
                stall_left--;
            end else if (mode == 1) begin
                dout_ready = cyc[0];
            end else begin
                dout_ready = 1'b1;
            end
            if (abort_idx >= 0 && dv && int'(dc) == abort_idx) begin
                rst_n = 1'b0;
                #1;
                check("abort_valid", dv, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_dout", dd, 0);
                return;
            end
            if (dv && first_v < 0) first_v = cyc;
            if (stalled) begin
                check("stall_dout", dd, hold_d);
                check("stall_count", dc, hold_c);
            end
            if (done) begin
                done_cyc = cyc;
                check("done_valid_low", dv, 0);
                check("done_busy_low", busy, 0);
                check("beats_accepted", exp_idx, 32);
            end else if (dv) begin
                if (dout_ready) begin
                    check("beat_index", dc, exp_idx);
                    if (exp_idx < 32)
                        check("beat_data", dd, {24'h0, expv[exp_idx*8 +: 8]});
                    if (inject && exp_idx == 10) begin
                        en = 1'b1;
                        a  = {8'h0, ~val};
                    end
                    exp_idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_d  = dd;
                    hold_c  = dc;
                end
            end
            if (done_cyc < 0) begin
                tick();
                cyc++;
            end
        end
        check("done_seen", done_cyc >= 0, 1);
        check("first_valid_cycle", first_v, frz ? 2 : 1);
        if (mode == 0)
            check("done_cycle", done_cyc, frz ? 34 : 33);
        if (inject) begin
            en = 1'b1;
            a  = {8'h0, ~val};
            tick();
            en = 1'b0;
            check("en_in_done_ignored_busy", busy, 0);
            check("en_in_done_ignored_valid", dv, 0);
        end else begin
            tick();
            check("done_single_pulse", done, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sel = 1'b1; a = '0; dout_ready = 1'b0;
        tick();
        tick();
        check("rst_busy_frz", busy1, 0);
        check("rst_valid_frz", dv1, 0);
        check("rst_done_frz", done1, 0);
        check("rst_dout_frz", dd1, 0);
        check("rst_count_frz", dc1, 0);
        check("rst_valid_raw", dv0, 0);
        check("rst_busy_raw", busy0, 0);
        rst_n = 1'b1;
        tick();

        run_op(1'b1, C_ONE,  C_ONE,  0, 1'b0, -1);
        run_op(1'b1, C_P,    C_ZERO, 0, 1'b0, -1);
        run_op(1'b1, C_P_M1, C_P_M1, 0, 1'b0, -1);
        run_op(1'b1, C_P_P5, C_FIVE, 0, 1'b0, -1);
        run_op(1'b0, C_P,    C_P,    0, 1'b0, -1);
        run_op(1'b1, C_RAMP, C_RAMP, 1, 1'b0, -1);
        run_op(1'b0, C_RAMP, C_RAMP, 1, 1'b0, -1);

        // Ignored en at idx 10 and in the done cycle, then an immediate new op.
        run_op(1'b1, C_RAMP, C_RAMP, 0, 1'b1, -1);
        run_op(1'b1, C_P_P5, C_FIVE, 0, 1'b0, -1);

        run_op(1'b1, C_RAMP, C_RAMP, 0, 1'b0, 20);
        tick();
        check("in_reset_valid", dv1, 0);
        rst_n = 1'b1;
        tick();
        check("post_reset_busy", busy1, 0);
        check("post_reset_dout", dd1, 0);
        run_op(1'b1, C_AB, C_AB, 0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
